// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the 1-cycle synchronous imem and loads IF/ID; first valid 2 edges after reset.
// stall freezes PC and IF/ID with imem_en low; branch_taken squashes and refills; HALT stops fetching.
module instr_fetch #(
  parameter int               PC_W     = 16,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter logic [31:0]      NOP_WORD = 32'hC800_0000,
  parameter logic [6:0]       HALT_OP  = 7'b1101000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_en,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     if_id_instr,
  output logic [PC_W-1:0] if_id_pc,
  output logic            if_id_valid,
  output logic            halted
);

  localparam logic [1:0] S_FILL   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0]      r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_req_pc;
  logic [31:0]     r_instr;
  logic [PC_W-1:0] r_if_id_pc;
  logic            r_valid;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_is_halt;

  assign w_pc_inc  = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign w_is_halt = (imem_rdata[31:25] == HALT_OP);

  // With imem_en low the memory keeps rdata, so a stalled RUN cycle still pairs rdata with req_pc.
  assign imem_addr   = r_pc;
  assign imem_en     = !stall && (r_state != S_HALTED);
  assign if_id_instr = r_instr;
  assign if_id_pc    = r_if_id_pc;
  assign if_id_valid = r_valid;
  assign halted      = (r_state == S_HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FILL;
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_instr    <= NOP_WORD;
      r_if_id_pc <= '0;
      r_valid    <= 1'b0;
    end else if (branch_taken) begin
      r_pc    <= branch_target;
      r_state <= S_FILL;
      r_valid <= 1'b0;
      r_instr <= NOP_WORD;
    end else if (!stall) begin
      case (r_state)
        S_FILL: begin
          r_req_pc <= r_pc;
          r_pc     <= w_pc_inc;
          r_state  <= S_RUN;
          r_valid  <= 1'b0;
        end
        S_RUN: begin
          r_instr    <= imem_rdata;
          r_if_id_pc <= r_req_pc;
          r_valid    <= 1'b1;
          r_req_pc   <= r_pc;
          r_pc       <= w_pc_inc;
          if (w_is_halt) r_state <= S_HALTED;
        end
        S_HALTED: begin
          // HALT has already been presented once; drop to a bubble.
          r_valid <= 1'b0;
          r_instr <= NOP_WORD;
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a 16-bit PC instance with a behavioural imem,
// plus a 4-bit PC instance starting at 14 to exercise wrap-around.
module tb_instr_fetch;

  localparam logic [31:0] NOP  = 32'hC800_0000;
  localparam logic [31:0] HALT = 32'hD000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic        if_id_valid, halted;

  logic        rst_b, stall_b, br_b;
  logic [3:0]  tgt_b, addr_b, pc_b;
  logic        en_b, valid_b, halted_b;
  logic [31:0] rdata_b, instr_b;

  logic [31:0] mem  [0:255];
  logic [31:0] memb [0:15];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch #(.PC_W(16), .RESET_PC(16'd0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_en(imem_en),
    .imem_rdata(imem_rdata), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid), .halted(halted)
  );

  instr_fetch #(.PC_W(4), .RESET_PC(4'd14)) dut_w (
    .clk(clk), .rst(rst_b), .stall(stall_b), .branch_taken(br_b),
    .branch_target(tgt_b), .imem_addr(addr_b), .imem_en(en_b),
    .imem_rdata(rdata_b), .if_id_instr(instr_b), .if_id_pc(pc_b),
    .if_id_valid(valid_b), .halted(halted_b)
  );

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr[7:0]];
    if (en_b)    rdata_b    <= memb[addr_b];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [31:0] ins, input logic [15:0] pc);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
    check({tag, ".instr"}, if_id_instr, ins);
    if (v) check({tag, ".pc"}, {16'd0, if_id_pc}, {16'd0, pc});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_1000 + i;
    for (int i = 0; i < 16; i++)  memb[i] = 32'h0000_0B00 + i;
    mem[0] = 32'h0100_000A; mem[1] = 32'h0100_000B; mem[2] = 32'h0100_000C;
    mem[3] = 32'h0100_000D; mem[4] = 32'h0100_000E; mem[5] = HALT;
    mem[8'h10] = 32'h0200_0010; mem[8'h40] = 32'h0300_0040; mem[8'h41] = 32'h0300_0041;

    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    rst_b = 1'b1; stall_b = 1'b0; br_b = 1'b0; tgt_b = '0;
    tick(); tick();
    check("rst.valid",  {31'd0, if_id_valid}, 32'd0);
    check("rst.instr",  if_id_instr, NOP);
    check("rst.pc",     {16'd0, if_id_pc}, 32'd0);
    check("rst.halted", {31'd0, halted}, 32'd0);
    check("rst.addr",   {16'd0, imem_addr}, 32'd0);
    check("rstw.pc",    {28'd0, addr_b}, 32'd14);

    // Stream A,B after reset release.
    rst = 1'b0;
    tick(); check_ifid("fill", 1'b0, NOP, 16'd0);
    tick(); check_ifid("A", 1'b1, 32'h0100_000A, 16'd0);
    tick(); check_ifid("B", 1'b1, 32'h0100_000B, 16'd1);

    // Stall three cycles holding B.
    stall = 1'b1; #1;
    check("stall.en", {31'd0, imem_en}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); check_ifid("stallB", 1'b1, 32'h0100_000B, 16'd1);
    end
    stall = 1'b0;
    tick(); check_ifid("C", 1'b1, 32'h0100_000C, 16'd2);

    // Redirect to 0x40 while C is in IF/ID; D must never appear.
    branch_taken = 1'b1; branch_target = 16'h0040;
    tick(); check_ifid("br.sq", 1'b0, NOP, 16'd0);
    branch_taken = 1'b0;
    tick(); check_ifid("br.bub", 1'b0, NOP, 16'd0);
    tick(); check_ifid("br.x40", 1'b1, 32'h0300_0040, 16'h0040);
    tick(); check_ifid("br.x41", 1'b1, 32'h0300_0041, 16'h0041);

    // Redirect to 4 so the HALT at 5 is reached.
    branch_taken = 1'b1; branch_target = 16'h0004;
    tick(); branch_taken = 1'b0;
    tick(); tick(); check_ifid("E", 1'b1, 32'h0100_000E, 16'd4);
    tick(); check_ifid("halt", 1'b1, HALT, 16'd5);
    check("halt.halted", {31'd0, halted}, 32'd1);
    tick(); check_ifid("halt.after", 1'b0, NOP, 16'd0);
    check("halted.after", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("halted.en", {31'd0, imem_en}, 32'd0);
      tick();
    end
    check("halted.addr", {16'd0, imem_addr}, 32'd7);
    check("halted.valid", {31'd0, if_id_valid}, 32'd0);

    // Leave HALTED via redirect asserted together with stall.
    branch_taken = 1'b1; branch_target = 16'h0010; stall = 1'b1;
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    check("unhalt.halted", {31'd0, halted}, 32'd0);
    check("unhalt.addr", {16'd0, imem_addr}, 32'h10);
    check_ifid("unhalt.sq", 1'b0, NOP, 16'd0);
    tick(); check_ifid("unhalt.bub", 1'b0, NOP, 16'd0);
    tick(); check_ifid("unhalt.x10", 1'b1, 32'h0200_0010, 16'h0010);
    tick(); check_ifid("unhalt.x11", 1'b1, 32'h0000_1011, 16'h0011);

    // Mid-stream reset.
    rst = 1'b1;
    tick();
    check("mrst.valid",  {31'd0, if_id_valid}, 32'd0);
    check("mrst.instr",  if_id_instr, NOP);
    check("mrst.pc",     {16'd0, if_id_pc}, 32'd0);
    check("mrst.halted", {31'd0, halted}, 32'd0);
    check("mrst.addr",   {16'd0, imem_addr}, 32'd0);
    rst = 1'b0;

    // 4-bit PC wrap from 14.
    rst_b = 1'b0;
    tick(); check("wrap.fill", {31'd0, valid_b}, 32'd0);
    tick(); check("wrap.pc0", {28'd0, pc_b}, 32'd14); check("wrap.i0", instr_b, 32'h0000_0B0E);
    tick(); check("wrap.pc1", {28'd0, pc_b}, 32'd15); check("wrap.i1", instr_b, 32'h0000_0B0F);
    tick(); check("wrap.pc2", {28'd0, pc_b}, 32'd0);  check("wrap.i2", instr_b, 32'h0000_0B00);
    tick(); check("wrap.pc3", {28'd0, pc_b}, 32'd1);  check("wrap.i3", instr_b, 32'h0000_0B01);
    check("wrap.valid", {31'd0, valid_b}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
